// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data sides, data first with a fetch starvation guard
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  input  logic        imem_flush,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t state;
  logic [SW-1:0] streak;
  logic drop, i_pend, d_pend, grant_d, grant_i, done;
  // a requester whose resp is high this cycle still holds its old request, so it is masked
  always_comb begin
    i_pend = |imem_rmask && !imem_resp && !imem_flush;
    d_pend = |(dmem_rmask | dmem_wmask) && !dmem_resp;
    grant_d = state == IDLE && d_pend && !(i_pend && streak == LIMIT);
    grant_i = state == IDLE && i_pend && !grant_d;
    done = state != IDLE && mem_resp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      streak <= '0;
      drop <= 1'b0;
      {mem_addr, mem_rmask, mem_wmask, mem_wdata} <= '0;
      imem_resp <= 1'b0;
      imem_rdata <= '0;
      dmem_resp <= 1'b0;
      dmem_rdata <= '0;
    end else begin
      imem_resp <= 1'b0;
      dmem_resp <= 1'b0;
      if (grant_d) begin
        state <= D_BUSY;
        streak <= i_pend ? streak + 1'b1 : '0;
        {mem_addr, mem_rmask, mem_wmask, mem_wdata} <= {dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata};
      end else if (grant_i) begin
        state <= I_BUSY;
        streak <= '0;
        drop <= 1'b0;
        {mem_addr, mem_rmask, mem_wmask, mem_wdata} <= {imem_addr, imem_rmask, 4'h0, 32'h0};
      end
      if (state == I_BUSY && imem_flush) drop <= 1'b1;
      // memory cannot abort, so a flushed fetch still runs to completion and is discarded here
      if (done) begin
        state <= IDLE;
        drop <= 1'b0;
        {mem_addr, mem_rmask, mem_wmask, mem_wdata} <= '0;
        if (state == I_BUSY && !drop && !imem_flush) begin
          imem_resp <= 1'b1;
          imem_rdata <= mem_rdata;
        end
        if (state == D_BUSY) begin
          dmem_resp <= 1'b1;
          if (|mem_rmask) dmem_rdata <= mem_rdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked against a transaction-level reference model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] imem_rmask, dmem_rmask, dmem_wmask, mem_rmask, mem_wmask;
  logic imem_flush, imem_resp, dmem_resp, mem_resp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_flush(imem_flush),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
  } txn_t;

  // reference model: who owns the port, what it asked for, and how long the fetch side has been passed over
  int owner = 0;
  txn_t cur = '{default: '0};
  int streak = 0;
  int wait_n = 0;
  int lat = 0;
  bit dropping = 0, m_iresp = 0, m_dresp = 0, stray = 0, rand_lat = 0, rand_rd = 0;
  logic [31:0] m_irdata = '0, m_drdata = '0;

  task automatic tick();
    bit iw, dw, take_d;
    iw = imem_rmask != 0 && !m_iresp && !imem_flush;
    dw = (dmem_rmask | dmem_wmask) != 0 && !m_dresp;
    take_d = dw && !(iw && streak >= LIMIT);
    @(posedge clk);
    m_iresp = 0;
    m_dresp = 0;
    if (rst) begin
      owner = 0; streak = 0; dropping = 0; wait_n = 0;
      cur = '{default: '0};
      m_irdata = '0; m_drdata = '0;
    end else if (owner == 0) begin
      if (take_d) begin
        owner = 2;
        cur = '{dmem_addr, dmem_wdata, dmem_rmask, dmem_wmask};
        streak = iw ? streak + 1 : 0;
      end else if (iw) begin
        owner = 1;
        cur = '{imem_addr, 32'h0, imem_rmask, 4'h0};
        streak = 0;
        dropping = 0;
      end
      wait_n = rand_lat ? int'($urandom_range(3)) : lat;
    end else begin
      if (owner == 1 && imem_flush) dropping = 1;
      if (mem_resp) begin
        if (owner == 1 && !dropping) begin m_iresp = 1; m_irdata = mem_rdata; end
        if (owner == 2) begin m_dresp = 1; if (cur.rmask != 0) m_drdata = mem_rdata; end
        owner = 0;
        dropping = 0;
        cur = '{default: '0};
      end
    end
    #1;
    mem_resp = (owner != 0 && wait_n == 0) || (owner == 0 && stray);
    if (owner != 0 && wait_n > 0) wait_n--;
    if (rand_rd) mem_rdata = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; imem_addr = '0; imem_rmask = '0; imem_flush = 0;
    dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1;
    tick(); tick();
    checks++;
    if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== 72'h0) begin
      errors++; $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_rmask, mem_wmask, mem_wdata});
    end
    checks++;
    if ({imem_resp, dmem_resp, imem_rdata, dmem_rdata} !== 66'h0) begin
      errors++; $display("FAIL reset_resp: got %h expected 0", {imem_resp, dmem_resp, imem_rdata, dmem_rdata});
    end
    rst = 0;
  endtask

  task automatic test_i_only();
    lat = 1; mem_rdata = 32'h0000_0013;
    imem_addr = 32'h6000_0000; imem_rmask = 4'hF;
    tick();
    checks++;
    if ({mem_addr, mem_rmask, mem_wmask} !== {32'h6000_0000, 4'hF, 4'h0}) begin
      errors++; $display("FAIL i_only_req: got %h %h %h expected 60000000 f 0", mem_addr, mem_rmask, mem_wmask);
    end
    tick();
    checks++;
    if (mem_rmask !== 4'hF) begin errors++; $display("FAIL i_only_hold: got %h expected f", mem_rmask); end
    tick();
    checks++;
    if ({imem_resp, imem_rdata, dmem_resp, mem_rmask} !== {1'b1, 32'h13, 1'b0, 4'h0}) begin
      errors++; $display("FAIL i_only_resp: got %b %h %b %h expected 1 00000013 0 0", imem_resp, imem_rdata, dmem_resp, mem_rmask);
    end
    imem_rmask = '0;
    tick();
    checks++;
    if (imem_resp !== 1'b0) begin errors++; $display("FAIL i_only_pulse: got %b expected 0", imem_resp); end
  endtask

  task automatic test_d_write();
    lat = 0;
    dmem_addr = 32'h7000_0010; dmem_wmask = 4'h3; dmem_wdata = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== {32'h7000_0010, 4'h0, 4'h3, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL d_write_req: got %h %h %h %h expected 70000010 0 3 deadbeef", mem_addr, mem_rmask, mem_wmask, mem_wdata);
    end
    tick();
    dmem_wmask = '0;
    checks++;
    if ({dmem_resp, dmem_rdata, imem_resp, mem_wmask} !== {1'b1, 32'h0, 1'b0, 4'h0}) begin
      errors++; $display("FAIL d_write_resp: got %b %h %b %h expected 1 00000000 0 0", dmem_resp, dmem_rdata, imem_resp, mem_wmask);
    end
    tick();
    checks++;
    if (dmem_resp !== 1'b0) begin errors++; $display("FAIL d_write_pulse: got %b expected 0", dmem_resp); end
  endtask

  task automatic test_simultaneous();
    lat = 0; mem_rdata = 32'hA5A5_0001;
    imem_addr = 32'h6000_0100; imem_rmask = 4'hF;
    dmem_addr = 32'h7000_0020; dmem_rmask = 4'hF;
    tick();
    checks++;
    if ({mem_addr, mem_rmask} !== {32'h7000_0020, 4'hF}) begin
      errors++; $display("FAIL simul_d_first: got %h %h expected 70000020 f", mem_addr, mem_rmask);
    end
    tick();
    dmem_rmask = '0;
    checks++;
    if ({dmem_resp, dmem_rdata, imem_resp} !== {1'b1, 32'hA5A5_0001, 1'b0}) begin
      errors++; $display("FAIL simul_d_resp: got %b %h %b expected 1 a5a50001 0", dmem_resp, dmem_rdata, imem_resp);
    end
    tick();
    mem_rdata = 32'h0000_1234;
    checks++;
    if ({mem_addr, mem_rmask} !== {32'h6000_0100, 4'hF}) begin
      errors++; $display("FAIL simul_i_next: got %h %h expected 60000100 f", mem_addr, mem_rmask);
    end
    tick();
    imem_rmask = '0;
    checks++;
    if ({imem_resp, imem_rdata} !== {1'b1, 32'h1234}) begin
      errors++; $display("FAIL simul_i_resp: got %b %h expected 1 00001234", imem_resp, imem_rdata);
    end
    tick();
  endtask

  // fetch waits throughout; flushing in each data-resp cycle keeps fetch from slipping in between loads
  task automatic test_starvation();
    logic [10:0] seq = '0;
    int n = 0;
    logic [3:0] prev = '0;
    lat = 0; rand_rd = 1;
    imem_addr = 32'h6000_0200; imem_rmask = 4'hF;
    dmem_addr = 32'h8000_0000; dmem_rmask = 4'hF;
    for (int c = 0; c < 200 && n < 11; c++) begin
      tick();
      if (mem_rmask != 0 && prev == 0) begin
        seq = {seq[9:0], mem_addr == 32'h6000_0200};
        n++;
      end
      prev = mem_rmask;
      imem_flush = m_dresp;
      imem_rmask = m_iresp ? 4'h0 : 4'hF;
    end
    checks++;
    if (n != 11 || seq !== 11'b00001000001) begin
      errors++; $display("FAIL starvation_order: got %0d txns pattern %b expected 11 txns pattern 00001000001", n, seq);
    end
    imem_rmask = '0; dmem_rmask = '0; imem_flush = 0;
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if ({mem_rmask, imem_resp, dmem_resp} !== 6'h0) begin
      errors++; $display("FAIL starvation_drain: got %h expected 0", {mem_rmask, imem_resp, dmem_resp});
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    prev = m_irdata;
    rand_rd = 0; lat = 2; mem_rdata = 32'hBAD0_0BAD;
    imem_addr = 32'h0000_0100; imem_rmask = 4'hF;
    tick();
    imem_flush = 1; imem_addr = 32'h0000_0200;
    tick();
    imem_flush = 0;
    tick();
    imem_flush = 1;
    tick();
    imem_flush = 0; mem_rdata = 32'h0000_0537;
    checks++;
    if ({imem_resp, imem_rdata, mem_rmask} !== {1'b0, prev, 4'h0}) begin
      errors++; $display("FAIL flush_drop: got %b %h %h expected 0 %h 0", imem_resp, imem_rdata, mem_rmask, prev);
    end
    tick();
    checks++;
    if ({mem_addr, mem_rmask} !== {32'h0000_0200, 4'hF}) begin
      errors++; $display("FAIL flush_refetch: got %h %h expected 00000200 f", mem_addr, mem_rmask);
    end
    tick(); tick(); tick();
    imem_rmask = '0;
    checks++;
    if ({imem_resp, imem_rdata} !== {1'b1, 32'h537}) begin
      errors++; $display("FAIL flush_next_resp: got %b %h expected 1 00000537", imem_resp, imem_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    lat = 3; mem_rdata = 32'h5555_AAAA;
    dmem_addr = 32'h7000_0040; dmem_rmask = 4'hF;
    tick();
    checks++;
    if (mem_rmask !== 4'hF) begin errors++; $display("FAIL rstmid_busy: got %h expected f", mem_rmask); end
    rst = 1; dmem_rmask = '0;
    tick();
    rst = 0; mem_resp = 1;
    checks++;
    if ({mem_addr, mem_rmask, mem_wdata, imem_resp, dmem_resp, imem_rdata, dmem_rdata} !== 134'h0) begin
      errors++; $display("FAIL rstmid_zero: got %h %h %b %b %h %h expected all 0", mem_addr, mem_rmask, imem_resp, dmem_resp, imem_rdata, dmem_rdata);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({dmem_resp, dmem_rdata, mem_rmask} !== 37'h0) begin
        errors++; $display("FAIL rstmid_straggler: got %b %h %h expected 0 0 0", dmem_resp, dmem_rdata, mem_rmask);
      end
      tick();
    end
  endtask

  task automatic test_random();
    rand_rd = 1; rand_lat = 1;
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(499) == 0;
      stray = $urandom_range(7) == 0;
      if (m_iresp || imem_rmask == 0) begin
        imem_rmask = $urandom_range(1) ? 4'hF : 4'h0;
        imem_addr = $urandom & 32'hFFFF_FFFC;
      end
      imem_flush = $urandom_range(11) == 0;
      if (imem_flush && imem_rmask != 0) imem_addr = $urandom & 32'hFFFF_FFFC;
      if (m_dresp || (dmem_rmask | dmem_wmask) == 0) begin
        dmem_addr = $urandom;
        dmem_wdata = $urandom;
        case ($urandom_range(2))
          0: begin dmem_rmask = '0; dmem_wmask = '0; end
          1: begin dmem_rmask = 4'($urandom_range(15, 1)); dmem_wmask = '0; end
          default: begin dmem_rmask = '0; dmem_wmask = 4'($urandom_range(15, 1)); end
        endcase
      end
      tick();
      checks++;
      if ({mem_addr, mem_rmask, mem_wmask, mem_wdata} !== {cur.addr, cur.rmask, cur.wmask, cur.wdata}) begin
        errors++; $display("FAIL random_mem cycle %0d: got %h %h %h %h expected %h %h %h %h", c,
          mem_addr, mem_rmask, mem_wmask, mem_wdata, cur.addr, cur.rmask, cur.wmask, cur.wdata);
      end
      checks++;
      if ({imem_resp, dmem_resp, imem_rdata, dmem_rdata} !== {m_iresp, m_dresp, m_irdata, m_drdata}) begin
        errors++; $display("FAIL random_resp cycle %0d: got %b %b %h %h expected %b %b %h %h", c,
          imem_resp, dmem_resp, imem_rdata, dmem_rdata, m_iresp, m_dresp, m_irdata, m_drdata);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_i_only();
    test_d_write();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
